dmem_access_unit: RTL
=====================

Name: dmem_access_unit

Overview:
- Initiator (MEM-stage load/store master) that drives the word-addressed DataMemory.
- Accepts byte-addressed load/store requests from the pipeline and checks alignment and range.
- Converts byte addresses to word indices; performs read-modify-write for byte/halfword stores.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the target memory; word indices >= MEM_WORDS are out of range.
- IDX_WIDTH, 10, width of the word index driven on MemAddress low bits (clog2 of MEM_WORDS).

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  unit can accept; high only in IDLE.
- ReqWrite  input  1  1 = store, 0 = load.
- ReqSize  input  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- ReqSigned  input  1  sign-extend loads (ignored for stores/word).
- ReqAddr  input  32  byte address.
- ReqWData  input  32  store data, right-justified.
- RespValid  output  1  one-cycle completion pulse.
- RespData  output  32  extended load data; 0 for stores/errors.
- RespError  output  1  valid with RespValid: misaligned, out-of-range or illegal size.
- MemAddress  output  32  word index (ReqAddr[IDX_WIDTH+1:2], zero-extended).
- MemWriteData  output  32  word to write.
- MemWrite  output  1  write strobe; memory writes on the Clk edge ending the cycle.
- MemRead  output  1  read qualifier.
- MemReadData  input  32  combinational read data from memory.

Behaviour:
- Reset (async, Rst_n low): state IDLE; RespValid, RespError, MemWrite, MemRead = 0; RespData, MemAddress, MemWriteData = 0. MemWrite must drop immediately, with no partial write.
- ReqReady = (state == IDLE), so it is 1 after reset release. Requests are ignored while Rst_n is low.
- Accept at edge k when ReqValid && ReqReady. Register addr, size, signed, wdata and write.
- Error check at accept: misaligned is half with Addr[0] != 0, or word with Addr[1:0] != 0. Also flag word index >= MEM_WORDS and ReqSize == 3.
  - On error, go to RESP with RespError = 1.
  - MemRead and MemWrite are never asserted for an errored request.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
  - IDLE -> LOAD (load), STORE (word store) or RMW_RD (byte/half store); IDLE -> RESP on error.
  - LOAD: MemRead = 1, MemAddress = index. At edge k+1, capture the extracted, extended lane into RespData; go to RESP.
  - STORE: MemWrite = 1, MemWriteData = wdata. The memory writes at edge k+1; go to RESP.
  - RMW_RD: MemRead = 1. At edge k+1, capture MemReadData into a merge register; go to RMW_WR.
  - RMW_WR: MemWrite = 1. MemWriteData = captured word with the selected lane replaced. Write at edge k+2; go to RESP.
  - RESP: RespValid = 1 for exactly one cycle, then IDLE.
- Latency from accept to RespValid: load or word store, 2 cycles; sub-word store, 3 cycles; error, 1 cycle.
- Byte order: little-endian. The lane is Addr[1:0] for bytes and Addr[1] for halfwords.
  - Load extension: sign-extend if ReqSigned, else zero-extend.
  - Store merge touches only the selected lane.
- MemWrite and MemRead are never high together. Outside the access states both are 0 and MemAddress holds its last value.
- RespData and RespError hold their values until the next RESP.

Decomposition:
- Package dmem_pkg: SIZE_BYTE/HALF/WORD constants, state encoding localparams, misalign-check function.
- Sub-module mem_lane_align (combinational): load-lane extract/extend and store-lane merge. It is shared by the LOAD and RMW paths.

Test Plan:
- Memory preloaded with word[i] = i for i = 0..9.
- Word load: lw at 0x14 -> RespValid 2 cycles after accept, RespData = 5, RespError = 0, MemRead high for exactly 1 cycle.
- Word store then load: sw 0xDEADBEEF at 0x20, then lw at 0x20 -> 0xDEADBEEF. MemWrite is high for exactly 1 cycle.
- Byte access:
  - sb 0x80 at 0x21 -> RMW takes 3 cycles.
  - lw at 0x20 -> 0xDEAD80EF.
  - lb at 0x21 -> 0xFFFFFF80; lbu at 0x21 -> 0x00000080.
  - sh 0xFFFF at 0x02 -> word0 = 0xFFFF0000.
- Errors: lh at 0x23, sw at 0x1000 and size 3 at 0x0 -> each gives RespValid 1 cycle after accept with RespError = 1 and RespData = 0. MemRead/MemWrite are never asserted and the memory is unchanged.
- Reset mid-op: assert Rst_n low during RMW_WR of sb 0x55 at 0x04 -> MemWrite falls asynchronously and word1 stays 1. After release, ReqReady = 1 and RespValid = 0.
- Back-to-back: hold ReqValid high for two lw ops (0x0, 0x24) -> second accepted only on the cycle after the first RespValid. Responses are 0 then 9, in order.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | dmem_pkg: shared sizes, FSM states and alignment helper.        |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mem_lane_align: little-endian lane extract/extend and merge.    |
// | Revision: 1.0                                                   |
// +----------------------------------------------------------------+
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:   load_data = rdata;
    endcase
  end

  // Sub-word stores replace only the addressed lane of the old word.
  always_comb begin
    store_data = rdata;
    case (size)
      SIZE_BYTE: store_data[{lane, 3'b000} +: 8] = wdata[7:0];
      SIZE_HALF: store_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default:   store_data = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------+
// | dmem_access_unit: byte-addressed load/store master for a        |
// | word-addressed data memory. Revision: 1.0                       |
// +----------------------------------------------------------------+
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_WIDTH = 10
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespError,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  state_t               state;
  state_t               next_state;
  logic [1:0]           lane;
  logic [1:0]           size;
  logic                 sign_ext;
  logic [31:0]          wdata;
  logic [31:0]          merge_word;
  logic [31:0]          resp_data;
  logic                 resp_error;
  logic [IDX_WIDTH-1:0] mem_index;
  logic                 req_err;
  logic [31:0]          align_rdata;
  logic [31:0]          load_data;
  logic [31:0]          store_data;

  always_comb begin
    req_err = (ReqSize == SIZE_ILLEGAL)
            || is_misaligned(ReqSize, ReqAddr[1:0])
            || (ReqAddr[31:2] >= 30'(MEM_WORDS));
  end

  // LOAD extracts straight from memory; RMW merges into the captured word.
  assign align_rdata = (state == ST_LOAD) ? MemReadData : merge_word;

  mem_lane_align u_align (
    .size       (size),
    .lane       (lane),
    .sign_ext   (sign_ext),
    .rdata      (align_rdata),
    .wdata      (wdata),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    ReqReady     = 1'b0;
    RespValid    = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemWriteData = 32'd0;
    case (state)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          if (req_err)                 next_state = ST_RESP;
          else if (!ReqWrite)          next_state = ST_LOAD;
          else if (ReqSize == SIZE_WORD) next_state = ST_STORE;
          else                         next_state = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        MemRead    = 1'b1;
        next_state = ST_RESP;
      end
      ST_STORE: begin
        MemWrite     = 1'b1;
        MemWriteData = store_data;
        next_state   = ST_RESP;
      end
      ST_RMW_RD: begin
        MemRead    = 1'b1;
        next_state = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        MemWrite     = 1'b1;
        MemWriteData = store_data;
        next_state   = ST_RESP;
      end
      ST_RESP: begin
        RespValid  = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lane       <= 2'd0;
      size       <= SIZE_BYTE;
      sign_ext   <= 1'b0;
      wdata      <= 32'd0;
      merge_word <= 32'd0;
      resp_data  <= 32'd0;
      resp_error <= 1'b0;
      mem_index  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ReqValid) begin
            lane     <= ReqAddr[1:0];
            size     <= ReqSize;
            sign_ext <= ReqSigned;
            wdata    <= ReqWData;
            // Errored requests leave the memory address untouched.
            if (req_err) begin
              resp_data  <= 32'd0;
              resp_error <= 1'b1;
            end else begin
              mem_index <= ReqAddr[IDX_WIDTH+1:2];
            end
          end
        end
        ST_LOAD: begin
          resp_data  <= load_data;
          resp_error <= 1'b0;
        end
        ST_STORE, ST_RMW_WR: begin
          resp_data  <= 32'd0;
          resp_error <= 1'b0;
        end
        ST_RMW_RD: merge_word <= MemReadData;
        default: ;
      endcase
    end
  end

  assign RespData   = resp_data;
  assign RespError  = resp_error;
  assign MemAddress = {{(32-IDX_WIDTH){1'b0}}, mem_index};

endmodule
`default_nettype wire
